// File: rtl/linear_params_loader_pkg.sv
// Shared definitions for the conv unit's linear-parameter loader.
package linear_params_loader_pkg;

   // Width of the DMA read-path AXI-Stream carrying packed parameters.
   localparam int unsigned axis_data_width = 64;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoadA = 2'd1,
      StLoadB = 2'd2,
      StDone  = 2'd3
   } load_state_e;

   // Ceiling log2: number of bits needed to index 'value' entries.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/linear_params_loader_param_beat_unpacker.sv
// One-beat holding register that hands out one parameter slot per clock.
module linear_params_loader_param_beat_unpacker
   import linear_params_loader_pkg::*;
#(
   parameter int unsigned param_width = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       loading,
   input  logic                       section_end,
   input  logic                       load_end,
   input  logic [axis_data_width-1:0] s_axis_data,
   input  logic                       s_axis_last,
   input  logic                       s_axis_valid,
   output logic                       s_axis_ready,
   output logic                       held_valid,
   output logic                       held_last,
   output logic                       beat_release,
   output logic [param_width-1:0]     slot_data
);

   localparam int unsigned slots_per_beat = axis_data_width / param_width;
   localparam int unsigned slot_width = (slots_per_beat > 1) ? clogb2(slots_per_beat) : 1;
   localparam logic [slot_width-1:0] last_slot = slot_width'(slots_per_beat - 1);

   logic [axis_data_width-1:0] data_q;
   logic                       valid_q;
   logic                       last_q;
   logic [slot_width-1:0]      slot_q;
   logic                       accept;

   // Release, ready and slot selection from the held beat.
   always_comb begin
      beat_release = valid_q && ((slot_q == last_slot) || section_end);
      // The release that ends the load must not pull in a beat of the next block.
      s_axis_ready = loading && (!valid_q || (beat_release && !load_end));
      accept       = s_axis_valid && s_axis_ready;
      held_valid   = valid_q;
      held_last    = last_q;
      slot_data    = data_q[32'(slot_q) * param_width +: param_width];
   end

   // Holding register: load on handshake, step slot per write, drop outside a load.
   always_ff @(posedge clk) begin
      if (!rst_n || !loading) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         slot_q  <= '0;
      end else if (accept) begin
         data_q  <= s_axis_data;
         last_q  <= s_axis_last;
         valid_q <= 1'b1;
         slot_q  <= '0;
      end else if (beat_release) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         slot_q  <= '0;
      end else if (valid_q) begin
         slot_q <= slot_q + slot_width'(1);
      end
   end

endmodule

// File: rtl/linear_params_loader.sv
// Streams packed A/B linear parameters from AXI-Stream into the conv parameter buffer.
module linear_params_loader
   import linear_params_loader_pkg::*;
#(
   parameter int unsigned kernal_param_data_width = 16,
   parameter int unsigned max_kernal_n            = 512,
   parameter int unsigned simulation_delay        = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               blk_start,
   output logic                               blk_idle,
   output logic                               blk_done,
   output logic                               blk_err,
   input  logic [15:0]                        kernal_n,
   input  logic [axis_data_width-1:0]         s_axis_data,
   input  logic                               s_axis_last,
   input  logic                               s_axis_valid,
   output logic                               s_axis_ready,
   output logic                               buffer_wen_a,
   output logic                               buffer_wen_b,
   output logic [15:0]                        buffer_waddr,
   output logic [kernal_param_data_width-1:0] buffer_din_a,
   output logic [kernal_param_data_width-1:0] buffer_din_b
);

   localparam logic [15:0] max_kn_idx = 16'(max_kernal_n - 1);

   // Registers update in zero time; simulation_delay only annotates gate-level output delay.
   if (simulation_delay > 0) begin : g_sim_delay
   end

   load_state_e state_q, state_d;
   logic [15:0] kn_q;
   logic [15:0] cnt_q;
   logic        err_q;

   logic                               wen_a_q, wen_b_q;
   logic [15:0]                        waddr_q;
   logic [kernal_param_data_width-1:0] din_a_q, din_b_q;

   logic                               loading;
   logic                               section_end;
   logic                               load_end;
   logic                               held_valid;
   logic                               held_last;
   logic                               beat_release;
   logic [kernal_param_data_width-1:0] slot_data;

   // Section/load termination conditions seen by both the FSM and the unpacker.
   always_comb begin
      loading     = (state_q == StLoadA) || (state_q == StLoadB);
      section_end = (cnt_q == kn_q);
      load_end    = beat_release && (held_last || ((state_q == StLoadB) && section_end));
   end

   linear_params_loader_param_beat_unpacker #(
      .param_width (kernal_param_data_width)
   ) u_unpacker (
      .clk          (clk),
      .rst_n        (rst_n),
      .loading      (loading),
      .section_end  (section_end),
      .load_end     (load_end),
      .s_axis_data  (s_axis_data),
      .s_axis_last  (s_axis_last),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .held_valid   (held_valid),
      .held_last    (held_last),
      .beat_release (beat_release),
      .slot_data    (slot_data)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a beat flagged last ends the load once its slots are written.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (blk_start) state_d = StLoadA;
         StLoadA: begin
            if (load_end) begin
               state_d = StDone;
            end else if (held_valid && section_end) begin
               state_d = StLoadB;
            end
         end
         StLoadB: if (load_end) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Kernel count latch, kernel counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kn_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if ((state_q == StIdle) && blk_start) begin
         kn_q  <= (kernal_n > max_kn_idx) ? max_kn_idx : kernal_n;
         err_q <= (kernal_n > max_kn_idx);
         cnt_q <= '0;
      end else if (state_q == StDone) begin
         err_q <= 1'b0;
      end else if (held_valid) begin
         if ((state_q == StLoadA) && section_end) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
         // Error unless the last flag coincides exactly with the final B parameter.
         if (load_end && (held_last != ((state_q == StLoadB) && section_end))) begin
            err_q <= 1'b1;
         end
      end
   end

   // Registered buffer write port; din holds its value between writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wen_a_q <= 1'b0;
         wen_b_q <= 1'b0;
         waddr_q <= '0;
         din_a_q <= '0;
         din_b_q <= '0;
      end else begin
         wen_a_q <= held_valid && (state_q == StLoadA);
         wen_b_q <= held_valid && (state_q == StLoadB);
         if (held_valid) begin
            waddr_q <= cnt_q;
         end
         if (held_valid && (state_q == StLoadA)) begin
            din_a_q <= slot_data;
         end
         if (held_valid && (state_q == StLoadB)) begin
            din_b_q <= slot_data;
         end
      end
   end

   // FSM outputs and write-port drive.
   always_comb begin
      blk_idle     = (state_q == StIdle);
      blk_done     = (state_q == StDone);
      blk_err      = (state_q == StDone) && err_q;
      buffer_wen_a = wen_a_q;
      buffer_wen_b = wen_b_q;
      buffer_waddr = waddr_q;
      buffer_din_a = din_a_q;
      buffer_din_b = din_b_q;
   end

endmodule

// File: tb/tb_linear_params_loader.sv
// Self-checking bench for linear_params_loader against a parameter-list reference model.
module tb_linear_params_loader;

   localparam int W    = 16;
   localparam int P    = 64 / W;
   localparam int MAXK = 512;

   typedef struct packed {
      logic          is_b;
      logic [15:0]   addr;
      logic [W-1:0]  data;
   } wr_t;

   logic          clk;
   logic          rst_n;
   logic          blk_start;
   logic          blk_idle;
   logic          blk_done;
   logic          blk_err;
   logic [15:0]   kernal_n;
   logic [63:0]   s_axis_data;
   logic          s_axis_last;
   logic          s_axis_valid;
   logic          s_axis_ready;
   logic          buffer_wen_a;
   logic          buffer_wen_b;
   logic [15:0]   buffer_waddr;
   logic [W-1:0]  buffer_din_a;
   logic [W-1:0]  buffer_din_b;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   stray_err = 0;
   int   both_wen = 0;
   int   first_wr_cyc = -1;
   int   last_wr_cyc = -1;
   logic err_at_done = 1'b0;
   wr_t  got_q[$];

   linear_params_loader #(
      .kernal_param_data_width (W),
      .max_kernal_n            (MAXK),
      .simulation_delay        (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blk_start    (blk_start),
      .blk_idle     (blk_idle),
      .blk_done     (blk_done),
      .blk_err      (blk_err),
      .kernal_n     (kernal_n),
      .s_axis_data  (s_axis_data),
      .s_axis_last  (s_axis_last),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .buffer_wen_a (buffer_wen_a),
      .buffer_wen_b (buffer_wen_b),
      .buffer_waddr (buffer_waddr),
      .buffer_din_a (buffer_din_a),
      .buffer_din_b (buffer_din_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic wr_t mk(input logic is_b, input int addr, input logic [W-1:0] data);
      wr_t r;
      r.is_b = is_b;
      r.addr = 16'(addr);
      r.data = data;
      return r;
   endfunction

   // Write-port observer, sampled away from the active edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (buffer_wen_a && buffer_wen_b) both_wen = both_wen + 1;
      if (buffer_wen_a) got_q.push_back(mk(1'b0, int'(buffer_waddr), buffer_din_a));
      if (buffer_wen_b) got_q.push_back(mk(1'b1, int'(buffer_waddr), buffer_din_b));
      if (buffer_wen_a || buffer_wen_b) begin
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
      end
      if (blk_done) begin
         done_cnt    = done_cnt + 1;
         err_at_done = blk_err;
      end
      if (blk_err && !blk_done) stray_err = stray_err + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one beat (optionally after an idle cycle) and wait for its handshake.
   task automatic send_beat(input logic [63:0] d, input logic l, input bit toggle);
      int guard;
      if (toggle) begin
         s_axis_valid = 1'b0;
         @(negedge clk);
      end
      s_axis_data  = d;
      s_axis_last  = l;
      s_axis_valid = 1'b1;
      guard = 0;
      while (!s_axis_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("beat_handshake", int'(s_axis_ready), 1);
      @(negedge clk);
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
   endtask

   task automatic start_block(input int kn);
      @(negedge clk);
      kernal_n  = 16'(kn);
      blk_start = 1'b1;
      @(negedge clk);
      blk_start = 1'b0;
   endtask

   // last_beat: -1 = last on the final B beat, otherwise the B beat index carrying last
   // (an index past the end means last is never asserted).
   task automatic run_block(input int kn, input bit toggle, input int last_beat,
                            input bit counting, input bit poke);
      logic [W-1:0] a[$];
      logic [W-1:0] b[$];
      wr_t          exp_q[$];
      logic [63:0]  d;
      int           eff, nbeats, last_pos, nb_words, b_beats, done_before, guard;
      bit           exp_err;
      eff      = (kn > MAXK - 1) ? MAXK - 1 : kn;
      nbeats   = (eff + P) / P;
      last_pos = (last_beat < 0) ? nbeats - 1 : last_beat;
      for (int i = 0; i <= eff; i++) begin
         a.push_back(counting ? W'(i + 1) : W'($urandom));
         b.push_back(counting ? W'(i + 11) : W'($urandom));
      end
      // Reference: all A parameters, then B parameters up to the end of the beat carrying last.
      nb_words = eff + 1;
      if (last_pos < nbeats - 1) nb_words = (last_pos + 1) * P;
      for (int i = 0; i <= eff; i++) exp_q.push_back(mk(1'b0, i, a[i]));
      for (int i = 0; i < nb_words; i++) exp_q.push_back(mk(1'b1, i, b[i]));
      exp_err = (kn > MAXK - 1) || (last_pos != nbeats - 1);
      b_beats = (last_pos < nbeats) ? last_pos + 1 : nbeats;

      got_q.delete();
      first_wr_cyc = -1;
      done_before  = done_cnt;
      start_block(kn);
      for (int j = 0; j < nbeats; j++) begin
         d = '0;
         for (int k = 0; k < P; k++) if (j * P + k <= eff) d[k*W +: W] = a[j*P + k];
         send_beat(d, 1'b0, toggle);
         if (poke && j == 0) begin
            kernal_n  = 16'd0;
            blk_start = 1'b1;
            @(negedge clk);
            blk_start = 1'b0;
         end
      end
      for (int j = 0; j < b_beats; j++) begin
         d = '0;
         for (int k = 0; k < P; k++) if (j * P + k <= eff) d[k*W +: W] = b[j*P + k];
         send_beat(d, (j == last_pos), toggle);
      end
      guard = 0;
      while (done_cnt == done_before && guard < 4 * eff + 200) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      check("done_pulse_count", done_cnt - done_before, 1);
      check("err_at_done", int'(err_at_done), int'(exp_err));
      check("idle_after_done", int'(blk_idle), 1);
      check("write_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         assert (got_q[i] === exp_q[i]) else begin
            fails++;
            $error("FAIL write[%0d] got b%0d@%0d=%0h expected b%0d@%0d=%0h", i,
                   got_q[i].is_b, got_q[i].addr, got_q[i].data,
                   exp_q[i].is_b, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   initial begin
      int guard;
      int done_before;
      rst_n        = 1'b0;
      blk_start    = 1'b0;
      kernal_n     = '0;
      s_axis_data  = '0;
      s_axis_last  = 1'b0;
      s_axis_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state.
      check("rst_idle", int'(blk_idle), 1);
      check("rst_done", int'(blk_done), 0);
      check("rst_err", int'(blk_err), 0);
      check("rst_ready", int'(s_axis_ready), 0);
      check("rst_wen_a", int'(buffer_wen_a), 0);
      check("rst_wen_b", int'(buffer_wen_b), 0);
      check("rst_waddr", int'(buffer_waddr), 0);
      check("rst_din_a", int'(buffer_din_a), 0);
      check("rst_din_b", int'(buffer_din_b), 0);

      // Beats offered while idle are not taken.
      got_q.delete();
      s_axis_data  = 64'h0004_0003_0002_0001;
      s_axis_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("idle_ready_low", int'(s_axis_ready), 0);
         @(negedge clk);
      end
      s_axis_valid = 1'b0;
      check("idle_no_writes", got_q.size(), 0);

      // Directed kn=5, counting data, with a spurious start mid-load.
      run_block(5, 1'b0, -1, 1'b1, 1'b1);
      // Same stimulus with valid toggling.
      run_block(5, 1'b1, -1, 1'b1, 1'b0);
      // kn=3 with valid held: eight back-to-back writes.
      run_block(3, 1'b0, -1, 1'b0, 1'b0);
      check("no_bubble_span", last_wr_cyc - first_wr_cyc + 1, 8);
      // kn=7, last on the first B beat.
      run_block(7, 1'b0, 0, 1'b0, 1'b0);
      // kn beyond buffer depth clamps to 511 and flags an error.
      run_block(600, 1'b0, -1, 1'b0, 1'b0);
      // Last never asserted.
      run_block(5, 1'b0, 1000, 1'b0, 1'b0);

      // Reset during LOAD_B at address 2.
      got_q.delete();
      done_before = done_cnt;
      start_block(7);
      for (int j = 0; j < 3; j++) send_beat({$urandom, $urandom}, 1'b0, 1'b0);
      guard = 0;
      while (!(buffer_wen_b && buffer_waddr == 16'd2) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("reset_point_reached", int'(buffer_wen_b && buffer_waddr == 16'd2), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_wen_a", int'(buffer_wen_a), 0);
      check("midrst_wen_b", int'(buffer_wen_b), 0);
      check("midrst_idle", int'(blk_idle), 1);
      check("midrst_ready", int'(s_axis_ready), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_done", done_cnt - done_before, 0);
      run_block(3, 1'b0, -1, 1'b0, 1'b0);

      // Randomized blocks.
      for (int r = 0; r < 6; r++) begin
         run_block(int'($urandom_range(0, 20)), 1'(($urandom_range(0, 1))), -1, 1'b0, 1'b0);
      end

      check("never_both_wen", both_wen, 0);
      check("no_err_without_done", stray_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
